wishbone_sram_slave: RTL
========================

// Module: wishbone_sram_slave
// PURPOSE
//  Wishbone classic single-transfer slave fronting an on-chip word-addressed SRAM.
//  Answers the CPU-side Wishbone master (instruction/data bus) with a programmable
//  number of wait states, per-byte write enables and an error response for unmapped addresses.
//  Sits on the bus fabric as the memory endpoint; one transfer in flight at a time.
// PARAMETERS
//  DEPTH_LOG2   10            log2 of memory depth in 32-bit words (1024 words = 4 KiB)
//  WAIT_STATES  1             extra cycles before ack, legal range 0..15
//  BASE_ADDR    32'h0000_0000 base byte address; must be aligned to 2^(DEPTH_LOG2+2)
// PORTS
//  clk       in   1   clock, all logic on rising edge
//  rst       in   1   reset, synchronous, active-high
//  wb_adr_i  in   32  byte address from master
//  wb_dat_i  in   32  write data
//  wb_we_i   in   1   1 = write, 0 = read
//  wb_sel_i  in   4   byte lane select; sel[n] covers bits 8n+7:8n
//  wb_cyc_i  in   1   bus cycle active
//  wb_stb_i  in   1   strobe, transfer requested
//  wb_dat_o  out  32  read data, valid only while wb_ack_o=1, else 32'h0
//  wb_ack_o  out  1   one-cycle transfer-complete pulse
//  wb_err_o  out  1   one-cycle error pulse (unmapped address)
// BEHAVIOUR
//  - Reset: state=IDLE, wait counter=0, wb_ack_o=0, wb_err_o=0, wb_dat_o=0. SRAM contents not cleared.
//  - req = wb_cyc_i & wb_stb_i. Hit = wb_adr_i[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2].
//  - Word index = wb_adr_i[DEPTH_LOG2+1:2]; wb_adr_i[1:0] ignored.
//  - FSM states IDLE, WAIT, RESP:
//    IDLE: on req at edge, latch adr/dat/we/sel/hit, counter<=WAIT_STATES.
//          Go to WAIT if WAIT_STATES>0, else RESP.
//    WAIT: counter decrements each cycle. At counter==1 go to RESP.
//          If req drops in WAIT, abort: go to IDLE, no ack/err, no write.
//    RESP: ack_o (hit) or err_o (miss) high for exactly this one cycle. Next state is always IDLE.
//  - Latency: req first sampled at end of cycle T; the response pulse is in cycle T+1+WAIT_STATES.
//    All outputs are registered.
//  - Write commit: on the edge entering RESP, hit and we only.
//    Each lane with sel[n]=1 is updated from latched data; sel=4'b0000 acks with no change.
//  - Read: SRAM read on the edge entering RESP; wb_dat_o = full word during RESP, sel ignored.
//    wb_dat_o returns to 0 the next cycle.
//  - Miss: err pulse at the same latency as ack, no SRAM access, wb_dat_o=0.
//  - req still high in the cycle after RESP: accepted in IDLE as a new transfer.
//    Master must drop stb after ack to avoid a repeat.
//  - Inputs change during WAIT/RESP: ignored; latched values are used.
//  - Reset mid-transfer: next cycle IDLE, no ack/err, pending write discarded.
//  - ack_o and err_o are never high together; neither is high outside RESP.
// TESTING
//  1. WAIT_STATES=2: write 0xDEADBEEF to 0x10, sel=1111, req in cycle T -> ack in T+3 only.
//     Read 0x10 -> dat_o=0xDEADBEEF in ack cycle, 0 otherwise.
//  2. Write 0x0000AA00 to 0x10, sel=0010 -> read 0x10 returns 0xDEADAAEF.
//     Write sel=0000 -> ack, word unchanged.
//  3. DEPTH_LOG2=10, BASE=0: read/write 0x0001_0000 -> err one cycle at ack latency, no ack,
//     dat_o=0, memory unchanged.
//  4. WAIT_STATES=3: write 0x12345678 to 0x20, drop stb after 1 wait cycle -> no ack/err,
//     later read of 0x20 returns old value.
//  5. WAIT_STATES=0: reads 0x0,0x4,0x8 with stb re-raised the cycle after each ack ->
//     ack 1 cycle after each req, correct data, no dropped or duplicated ack.
//  6. rst asserted in WAIT of a write to 0x30 -> ack/err stay 0, state IDLE,
//     read 0x30 afterwards returns prior contents.

Source files
------------

// File: rtl/wishbone_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : wishbone_sram_slave
// Description : Wishbone classic slave over a word-addressed on-chip SRAM with
//               programmable wait states, byte lanes and unmapped-address error.
// Revision    : 1.0 - initial release
// ============================================================================
module wishbone_sram_slave #(
   parameter int          DEPTH_LOG2  = 10,
   parameter int          WAIT_STATES = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_we_i,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        wb_err_o
);

   localparam int         c_DEPTH     = 1 << DEPTH_LOG2;
   localparam logic [3:0] c_WAIT_INIT = 4'(WAIT_STATES);

   localparam logic [1:0] c_ST_IDLE = 2'd0;
   localparam logic [1:0] c_ST_WAIT = 2'd1;
   localparam logic [1:0] c_ST_RESP = 2'd2;

   logic [1:0]            r_state;
   logic [1:0]            w_state_nxt;
   logic [3:0]            r_cnt;
   logic [DEPTH_LOG2-1:0] r_idx;
   logic [31:0]           r_wdat;
   logic                  r_we;
   logic [3:0]            r_sel;
   logic                  r_hit;
   logic [31:0]           r_dat_o;
   logic                  r_ack;
   logic                  r_err;
   logic [31:0]           r_mem [c_DEPTH];

   logic                  w_req;
   logic                  w_hit_in;
   logic                  w_enter_resp;
   logic                  w_cur_hit;
   logic                  w_cur_we;
   logic [3:0]            w_cur_sel;
   logic [31:0]           w_cur_dat;
   logic [DEPTH_LOG2-1:0] w_cur_idx;
   logic                  w_mem_wr;
   logic                  w_mem_rd;
   logic                  w_unused_ok;

   assign w_req       = wb_cyc_i & wb_stb_i;
   assign w_hit_in    = (wb_adr_i[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2]);
   assign w_unused_ok = &{1'b0, wb_adr_i[1:0]};

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= c_ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state logic; a dropped request during WAIT aborts the transfer
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE: begin
            if (w_req) w_state_nxt = (c_WAIT_INIT != 4'd0) ? c_ST_WAIT : c_ST_RESP;
         end
         c_ST_WAIT: begin
            if (!w_req)              w_state_nxt = c_ST_IDLE;
            else if (r_cnt == 4'd1)  w_state_nxt = c_ST_RESP;
         end
         c_ST_RESP: w_state_nxt = c_ST_IDLE;
         default:   w_state_nxt = c_ST_IDLE;
      endcase
   end

   // Output decode; with zero wait states RESP is entered straight from IDLE,
   // so the live bus values stand in for the not-yet-latched copies.
   always_comb begin
      w_enter_resp = (w_state_nxt == c_ST_RESP);
      w_cur_hit    = r_hit;
      w_cur_we     = r_we;
      w_cur_sel    = r_sel;
      w_cur_dat    = r_wdat;
      w_cur_idx    = r_idx;
      if (r_state == c_ST_IDLE) begin
         w_cur_hit = w_hit_in;
         w_cur_we  = wb_we_i;
         w_cur_sel = wb_sel_i;
         w_cur_dat = wb_dat_i;
         w_cur_idx = wb_adr_i[DEPTH_LOG2+1:2];
      end
      w_mem_wr = w_enter_resp & w_cur_hit & w_cur_we & ~rst;
      w_mem_rd = w_enter_resp & w_cur_hit & ~w_cur_we;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt   <= 4'd0;
         r_idx   <= '0;
         r_wdat  <= 32'h0;
         r_we    <= 1'b0;
         r_sel   <= 4'h0;
         r_hit   <= 1'b0;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_dat_o <= 32'h0;
      end else begin
         r_ack   <= w_enter_resp & w_cur_hit;
         r_err   <= w_enter_resp & ~w_cur_hit;
         r_dat_o <= w_mem_rd ? r_mem[w_cur_idx] : 32'h0;
         if (r_state == c_ST_IDLE && w_req) begin
            r_cnt  <= c_WAIT_INIT;
            r_idx  <= wb_adr_i[DEPTH_LOG2+1:2];
            r_wdat <= wb_dat_i;
            r_we   <= wb_we_i;
            r_sel  <= wb_sel_i;
            r_hit  <= w_hit_in;
         end else if (r_state == c_ST_WAIT) begin
            r_cnt <= w_req ? (r_cnt - 4'd1) : 4'd0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_mem_wr) begin
         for (int n = 0; n < 4; n++) begin
            if (w_cur_sel[n]) r_mem[w_cur_idx][8*n +: 8] <= w_cur_dat[8*n +: 8];
         end
      end
   end

   assign wb_dat_o = r_dat_o;
   assign wb_ack_o = r_ack;
   assign wb_err_o = r_err;

endmodule
`default_nettype wire
